// File: rtl/rip_common_pkg.sv
// ----------------------------------------------------------------------------
// rip_common: shared widths, the decoded-instruction flag struct and the
// load/store helpers (access size, size mask, load/store classification).
// ----------------------------------------------------------------------------
package rip_common;

   localparam int DATA_WIDTH = 32;                // data word width
   localparam int ADDR_WIDTH = 30;                // word-address width of memory port
   localparam int NUM_COL    = 4;                 // byte lanes per word
   localparam int OFF_W      = $clog2(NUM_COL);   // byte-offset width

   // Decoded memory-instruction flags; at most one is expected to be set.
   typedef struct packed {
      logic lb;
      logic lh;
      logic lw;
      logic lbu;
      logic lhu;
      logic sb;
      logic sh;
      logic sw;
   } inst_t;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

   typedef enum logic [1:0] {ST_IDLE, ST_FIRST, ST_SECOND} lsu_state_e;

   function automatic size_e access_size(input inst_t i);
      if (i.lb | i.lbu | i.sb)      return SZ_B;
      else if (i.lh | i.lhu | i.sh) return SZ_H;
      else                          return SZ_W;
   endfunction

   function automatic logic [NUM_COL-1:0] size_mask(input inst_t i);
      case (access_size(i))
         SZ_B:    return 4'b0001;
         SZ_H:    return 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic is_load(input inst_t i);
      return i.lb | i.lh | i.lw | i.lbu | i.lhu;
   endfunction

   function automatic logic is_store(input inst_t i);
      return i.sb | i.sh | i.sw;
   endfunction

endpackage

// File: rtl/rip_lsu_align.sv
// ----------------------------------------------------------------------------
// rip_lsu_align: combinational lane alignment for the LSU.
//   Store side: st_mask/st_off/st_wdata -> lmask (8-lane mask spanning two
//               words), st_wdata_rot (store data rotated onto its lanes).
//   Load side : ld_size/ld_signed/ld_off/word_a/word_b -> ld_data (extracted
//               from the {word_b, word_a} pair and sign/zero extended).
// ----------------------------------------------------------------------------
module rip_lsu_align
#(
   parameter int DATA_WIDTH = rip_common::DATA_WIDTH,
   parameter int NUM_COL    = rip_common::NUM_COL
)(
   input  logic [NUM_COL-1:0]           st_mask,
   input  logic [rip_common::OFF_W-1:0] st_off,
   input  logic [DATA_WIDTH-1:0]        st_wdata,
   output logic [2*NUM_COL-1:0]         lmask,
   output logic [DATA_WIDTH-1:0]        st_wdata_rot,
   input  rip_common::size_e            ld_size,
   input  logic                         ld_signed,
   input  logic [rip_common::OFF_W-1:0] ld_off,
   input  logic [DATA_WIDTH-1:0]        word_a,
   input  logic [DATA_WIDTH-1:0]        word_b,
   output logic [DATA_WIDTH-1:0]        ld_data
);
   import rip_common::*;

   logic [2*DATA_WIDTH-1:0] st_pair;
   logic [2*DATA_WIDTH-1:0] ld_pair;
   logic [DATA_WIDTH-1:0]   ld_raw;

   assign lmask   = {{NUM_COL{1'b0}}, st_mask} << st_off;
   assign st_pair = {st_wdata, st_wdata};
   assign ld_pair = {word_b, word_a};

   // Rotate-left by 8*off: the window into {x,x} starting 8*off below the top.
   // NOTE: every always_comb output gets a default first so no path can leave
   // it unassigned and infer a latch.
   always_comb begin
      st_wdata_rot = st_pair[DATA_WIDTH - 8*int'(st_off) +: DATA_WIDTH];
      ld_raw       = ld_pair[8*int'(ld_off) +: DATA_WIDTH];
      ld_data      = ld_raw;
      case (ld_size)
         SZ_B: ld_data = {{(DATA_WIDTH-8){ld_signed & ld_raw[7]}}, ld_raw[7:0]};
         SZ_H: ld_data = {{(DATA_WIDTH-16){ld_signed & ld_raw[15]}}, ld_raw[15:0]};
         default: ld_data = ld_raw;
      endcase
   end

endmodule

// File: rtl/rip_lsu.sv
// ----------------------------------------------------------------------------
// rip_lsu: load/store initiator between the MA stage and a byte-lane,
// word-addressed data memory with 1-cycle read latency.
//   clk, rstn (sync, active-low)
//   req_valid/req_ready/req_inst/req_addr/req_wdata : request from pipeline
//   resp_valid/resp_rdata                           : one-cycle completion
//   mem_en/mem_addr/mem_we/mem_wdata/mem_rdata      : memory port
// Word-crossing accesses are split into two consecutive word accesses.
// ----------------------------------------------------------------------------
module rip_lsu
#(
   parameter int DATA_WIDTH = rip_common::DATA_WIDTH,
   parameter int ADDR_WIDTH = rip_common::ADDR_WIDTH,
   parameter int NUM_COL    = rip_common::NUM_COL
)(
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  rip_common::inst_t       req_inst,
   input  logic [DATA_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   output logic                    resp_valid,
   output logic [DATA_WIDTH-1:0]   resp_rdata,
   output logic                    mem_en,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [NUM_COL-1:0]      mem_we,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);
   import rip_common::*;

   lsu_state_e              state, state_nxt;
   inst_t                   inst_q;
   logic [OFF_W-1:0]        off_q;
   logic [ADDR_WIDTH-1:0]   waddr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [NUM_COL-1:0]      lmask_hi_q;   // lanes of the second word, 0 if aligned
   logic [DATA_WIDTH-1:0]   word_a_q;

   logic [2*NUM_COL-1:0]    lmask;
   logic [DATA_WIDTH-1:0]   st_rot;
   logic [DATA_WIDTH-1:0]   ld_data;
   logic                    accept;
   logic                    misal_q;
   logic                    resp_fire;

   assign accept    = rstn && (state == ST_IDLE) && req_valid
                      && (is_load(req_inst) || is_store(req_inst));
   assign misal_q   = |lmask_hi_q;
   assign resp_fire = ((state == ST_FIRST) && !misal_q) || (state == ST_SECOND);

   rip_lsu_align #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_COL    (NUM_COL)
   ) u_align (
      .st_mask      (size_mask(req_inst)),
      .st_off       (req_addr[OFF_W-1:0]),
      .st_wdata     (req_wdata),
      .lmask        (lmask),
      .st_wdata_rot (st_rot),
      .ld_size      (access_size(inst_q)),
      .ld_signed    (inst_q.lb | inst_q.lh),
      .ld_off       (off_q),
      // Aligned loads finish in FIRST with both halves taken from the live word.
      .word_a       ((state == ST_SECOND) ? word_a_q : mem_rdata),
      .word_b       (mem_rdata),
      .ld_data      (ld_data)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its inputs.
   always_ff @(posedge clk) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (accept) state_nxt = ST_FIRST;
         ST_FIRST:  state_nxt = misal_q ? ST_SECOND : ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Memory-side outputs; reset suppresses any access, including a pending
   // second half of a split store.
   always_comb begin
      req_ready = (state == ST_IDLE);
      mem_en    = 1'b0;
      mem_addr  = '0;
      mem_we    = '0;
      mem_wdata = '0;
      case (state)
         ST_IDLE: if (accept) begin
            mem_en    = 1'b1;
            mem_addr  = req_addr[ADDR_WIDTH+1:2];
            mem_we    = is_store(req_inst) ? lmask[NUM_COL-1:0] : '0;
            mem_wdata = st_rot;
         end
         ST_FIRST: if (rstn && misal_q) begin
            mem_en    = 1'b1;
            mem_addr  = waddr_q + 1'b1;   // wraps to word 0 at the top
            mem_we    = is_store(inst_q) ? lmask_hi_q : '0;
            mem_wdata = wdata_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         inst_q     <= '0;
         off_q      <= '0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         lmask_hi_q <= '0;
         word_a_q   <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
      end else begin
         if (accept) begin
            inst_q     <= req_inst;
            off_q      <= req_addr[OFF_W-1:0];
            waddr_q    <= req_addr[ADDR_WIDTH+1:2];
            wdata_q    <= st_rot;
            lmask_hi_q <= lmask[2*NUM_COL-1:NUM_COL];
         end
         if (state == ST_FIRST) word_a_q <= mem_rdata;
         resp_valid <= resp_fire;
         if (resp_fire) resp_rdata <= is_load(inst_q) ? ld_data : '0;
      end
   end

endmodule
